// File: rtl/fetch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ctrl_pkg
// Description : Definitions shared by the fetch stage and the fetch front-end
//               controller: BRAM address width, core mode encodings, the
//               default reset pc, and the {inst, pc} fetch entry record.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_ctrl_pkg;

   // Instruction BRAM address width; the word index is pc[INST_SIZE+1:2].
   localparam int INST_SIZE = 10;

   // Core mode encodings. Values not listed here behave as MODE_STALL.
   localparam logic [2:0] MODE_STALL = 3'd0;
   localparam logic [2:0] MODE_LOAD  = 3'd1;
   localparam logic [2:0] MODE_EXEC  = 3'd2;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   // One fetched instruction paired with the address it came from.
   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
   } fetch_entry_t;

   // Instruction BRAM word index for a byte pc.
   function automatic logic [INST_SIZE-1:0] word_index(input logic [31:0] pc);
      return pc[INST_SIZE+1:2];
   endfunction

endpackage : fetch_ctrl_pkg
`default_nettype wire

// File: rtl/fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ctrl_if
// Description : Bus between the fetch front-end controller, the fetch stage
//               (pc out / inst_in back one cycle later) and decode
//               (out_valid/out_ready handshake carrying out_inst/out_pc).
//   pc        : fetch address (synchronous BRAM address)
//   inst_in   : instruction read at the pc issued on the previous cycle
//   out_valid : instruction available to decode
//   out_ready : decode accepts this cycle
//   out_inst  : instruction to decode
//   out_pc    : pc of out_inst
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_ctrl_if;
   logic [31:0] pc;
   logic [31:0] inst_in;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_inst;
   logic [31:0] out_pc;

   // Controller side.
   modport master (
      output pc,
      input  inst_in,
      output out_valid,
      input  out_ready,
      output out_inst,
      output out_pc
   );

   // Fetch stage / decode side.
   modport slave (
      input  pc,
      output inst_in,
      input  out_valid,
      output out_ready,
      input  out_inst,
      input  out_pc
   );
endinterface : fetch_ctrl_if
`default_nettype wire

// File: rtl/fetch_ctrl_skid.sv
`default_nettype none
// ============================================================================
// Module      : fetch_skid
// Description : One-entry skid register holding a fetch_entry_t. Absorbs the
//               instruction returning from BRAM while decode is stalled.
//   clk, rstn : clock, asynchronous active-low reset
//   i_load    : capture i_entry (only used while empty)
//   i_clear   : entry consumed by decode
//   i_flush   : discard entry (redirect / LOAD); wins over load and clear
//   i_entry   : entry to capture
//   o_valid   : entry held
//   o_entry   : held entry
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_skid
   import fetch_ctrl_pkg::*;
(
   input  wire logic         clk,
   input  wire logic         rstn,
   input  wire logic         i_load,
   input  wire logic         i_clear,
   input  wire logic         i_flush,
   input  wire fetch_entry_t i_entry,
   output      logic         o_valid,
   output      fetch_entry_t o_entry
);

   logic         r_valid;
   fetch_entry_t r_entry;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_valid <= 1'b0;
      end else if (i_flush) begin
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_valid <= 1'b1;
      end else if (i_clear) begin
         r_valid <= 1'b0;
      end
   end

   // Payload only changes on capture so a held entry stays stable.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_entry <= '0;
      end else if (i_load && !i_flush) begin
         r_entry <= i_entry;
      end
   end

   assign o_valid = r_valid;
   assign o_entry = r_entry;

endmodule : fetch_skid
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ctrl
// Description : Fetch front-end controller. Owns the program counter, issues
//               one BRAM request per cycle, tracks the 1-cycle read latency,
//               pairs each returned instruction with its pc and hands it to
//               decode over a valid/ready handshake. A one-entry skid buffer
//               absorbs decode stalls; redirects squash wrong-path fetches.
//   clk         : system clock
//   rstn        : asynchronous active-low reset
//   mode        : STALL=0, LOAD=1, EXEC=2, others behave as STALL
//   redirect    : taken branch/jump pulse from execute
//   redirect_pc : redirect target (bits [1:0] forced to 0)
//   bus         : fetch/decode bus (master side)
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
)(
   input  wire logic        clk,
   input  wire logic        rstn,
   input  wire logic [2:0]  mode,
   input  wire logic        redirect,
   input  wire logic [31:0] redirect_pc,
   fetch_ctrl_if.master     bus
);

   logic [31:0]  r_pc_q;
   logic         r_inflight_v;
   logic [31:0]  r_inflight_pc;

   logic         w_is_exec;
   logic         w_is_load;
   logic         w_issue;
   logic         w_skid_v;
   fetch_entry_t w_skid_entry;
   fetch_entry_t w_fetch_entry;
   logic         w_skid_load;
   logic         w_skid_clear;
   logic         w_skid_flush;
   logic         w_out_valid;
   logic [31:0]  w_out_inst;
   logic [31:0]  w_out_pc;

   assign w_is_exec = (mode == MODE_EXEC);
   assign w_is_load = (mode == MODE_LOAD);

   // A new request is only issued when its data is guaranteed a home next
   // cycle: the skid is empty and the current in-flight word is leaving.
   assign w_issue = w_is_exec && !redirect && !w_skid_v
                    && !(r_inflight_v && !bus.out_ready);

   assign w_fetch_entry = '{inst: bus.inst_in, pc: r_inflight_pc};

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_pc_q        <= RESET_PC;
         r_inflight_v  <= 1'b0;
         r_inflight_pc <= '0;
      end else if (w_is_load) begin
         r_pc_q        <= RESET_PC;
         r_inflight_v  <= 1'b0;
      end else if (redirect) begin
         r_pc_q        <= {redirect_pc[31:2], 2'b00};
         r_inflight_v  <= 1'b0;
      end else if (w_issue) begin
         r_pc_q        <= r_pc_q + 32'd4;
         r_inflight_v  <= 1'b1;
         r_inflight_pc <= r_pc_q;
      end else begin
         r_inflight_v  <= 1'b0;
      end
   end

   // Redirect and LOAD hide everything pending, including the skid entry.
   always_comb begin
      w_out_valid = 1'b0;
      w_out_inst  = '0;
      w_out_pc    = '0;
      if (!w_is_load && !redirect) begin
         if (w_skid_v) begin
            w_out_valid = 1'b1;
            w_out_inst  = w_skid_entry.inst;
            w_out_pc    = w_skid_entry.pc;
         end else if (r_inflight_v) begin
            w_out_valid = 1'b1;
            w_out_inst  = w_fetch_entry.inst;
            w_out_pc    = w_fetch_entry.pc;
         end
      end
   end

   assign w_skid_flush = w_is_load || redirect;
   assign w_skid_load  = r_inflight_v && !w_skid_v && !bus.out_ready && !redirect;
   assign w_skid_clear = w_skid_v && w_out_valid && bus.out_ready;

   fetch_skid u_skid (
      .clk     (clk),
      .rstn    (rstn),
      .i_load  (w_skid_load),
      .i_clear (w_skid_clear),
      .i_flush (w_skid_flush),
      .i_entry (w_fetch_entry),
      .o_valid (w_skid_v),
      .o_entry (w_skid_entry)
   );

   assign bus.pc        = w_is_load ? RESET_PC : r_pc_q;
   assign bus.out_valid = w_out_valid;
   assign bus.out_inst  = w_out_inst;
   assign bus.out_pc    = w_out_pc;

endmodule : fetch_ctrl
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_ctrl
// Description : Self-checking bench for fetch_ctrl. A synchronous BRAM model
//               returns 0x1000 + word_index(pc) one cycle after each pc.
//               Directed vectors hold per-cycle inputs and expected outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;
   import fetch_ctrl_pkg::*;

   localparam logic [2:0] S = MODE_STALL;
   localparam logic [2:0] L = MODE_LOAD;
   localparam logic [2:0] E = MODE_EXEC;
   localparam logic [2:0] X = 3'd3;

   typedef struct {
      logic [2:0]  mode;
      logic        redir;
      logic [31:0] rpc;
      logic        ready;
      logic [31:0] exp_pc;
      logic        exp_valid;
      logic [31:0] exp_inst;
      logic [31:0] exp_opc;
   } vec_t;

   logic        clk;
   logic        rstn;
   logic [2:0]  mode;
   logic        redirect;
   logic [31:0] redirect_pc;
   int          errors;
   int          checks;
   vec_t        vecs[31];

   fetch_ctrl_if ifc ();

   fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
      .clk         (clk),
      .rstn        (rstn),
      .mode        (mode),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .bus         (ifc.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous instruction BRAM model.
   always @(posedge clk) begin
      ifc.inst_in <= 32'h1000 + 32'(word_index(ifc.pc));
   end

   // skid and in-flight must never both be occupied.
   always @(negedge clk) begin
      if (rstn) begin
         checks++;
         assert (!(dut.w_skid_v && dut.r_inflight_v)) else begin
            errors++;
            $display("FAIL invariant: skid_v=%0b inflight_v=%0b both set",
                     dut.w_skid_v, dut.r_inflight_v);
         end
      end
   end

   function automatic vec_t mk(input logic [2:0] m, input logic r,
                               input logic [31:0] rp, input logic rdy,
                               input logic [31:0] epc, input logic ev,
                               input logic [31:0] ei, input logic [31:0] eo);
      vec_t v;
      v.mode = m; v.redir = r; v.rpc = rp; v.ready = rdy;
      v.exp_pc = epc; v.exp_valid = ev; v.exp_inst = ei; v.exp_opc = eo;
      return v;
   endfunction

   task automatic check32(input string name, input logic [31:0] act,
                          input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_outs(input string tag, input logic [31:0] epc,
                             input logic ev, input logic [31:0] ei,
                             input logic [31:0] eo);
      check32({tag, " pc"},        ifc.pc,                epc);
      check32({tag, " out_valid"}, {31'd0, ifc.out_valid}, {31'd0, ev});
      check32({tag, " out_inst"},  ifc.out_inst,          ei);
      check32({tag, " out_pc"},    ifc.out_pc,            eo);
   endtask

   initial begin
      errors = 0;
      checks = 0;
      //            mode rd rpc           rdy  pc            v  inst          out_pc
      vecs[0]  = mk(L, 0, 32'h0,         1, 32'h00,        0, 32'h0,    32'h0);
      vecs[1]  = mk(E, 0, 32'h0,         1, 32'h00,        0, 32'h0,    32'h0);
      vecs[2]  = mk(E, 0, 32'h0,         1, 32'h04,        1, 32'h1000, 32'h00);
      vecs[3]  = mk(E, 0, 32'h0,         1, 32'h08,        1, 32'h1001, 32'h04);
      vecs[4]  = mk(E, 0, 32'h0,         0, 32'h0C,        1, 32'h1002, 32'h08);
      vecs[5]  = mk(E, 0, 32'h0,         0, 32'h0C,        1, 32'h1002, 32'h08);
      vecs[6]  = mk(E, 0, 32'h0,         0, 32'h0C,        1, 32'h1002, 32'h08);
      vecs[7]  = mk(E, 0, 32'h0,         1, 32'h0C,        1, 32'h1002, 32'h08);
      vecs[8]  = mk(E, 0, 32'h0,         1, 32'h0C,        0, 32'h0,    32'h0);
      vecs[9]  = mk(E, 0, 32'h0,         1, 32'h10,        1, 32'h1003, 32'h0C);
      vecs[10] = mk(E, 1, 32'h43,        1, 32'h14,        0, 32'h0,    32'h0);
      vecs[11] = mk(E, 0, 32'h0,         1, 32'h40,        0, 32'h0,    32'h0);
      vecs[12] = mk(E, 0, 32'h0,         1, 32'h44,        1, 32'h1010, 32'h40);
      vecs[13] = mk(E, 0, 32'h0,         0, 32'h48,        1, 32'h1011, 32'h44);
      vecs[14] = mk(E, 0, 32'h0,         0, 32'h48,        1, 32'h1011, 32'h44);
      vecs[15] = mk(E, 1, 32'h80,        1, 32'h48,        0, 32'h0,    32'h0);
      vecs[16] = mk(E, 0, 32'h0,         1, 32'h80,        0, 32'h0,    32'h0);
      vecs[17] = mk(E, 0, 32'h0,         1, 32'h84,        1, 32'h1020, 32'h80);
      vecs[18] = mk(S, 0, 32'h0,         1, 32'h88,        1, 32'h1021, 32'h84);
      vecs[19] = mk(S, 0, 32'h0,         1, 32'h88,        0, 32'h0,    32'h0);
      vecs[20] = mk(E, 0, 32'h0,         1, 32'h88,        0, 32'h0,    32'h0);
      vecs[21] = mk(E, 0, 32'h0,         1, 32'h8C,        1, 32'h1022, 32'h88);
      vecs[22] = mk(X, 0, 32'h0,         1, 32'h90,        1, 32'h1023, 32'h8C);
      vecs[23] = mk(X, 0, 32'h0,         1, 32'h90,        0, 32'h0,    32'h0);
      vecs[24] = mk(E, 1, 32'hFFFFFFFE,  1, 32'h90,        0, 32'h0,    32'h0);
      vecs[25] = mk(E, 0, 32'h0,         1, 32'hFFFFFFFC,  0, 32'h0,    32'h0);
      vecs[26] = mk(E, 0, 32'h0,         1, 32'h00,        1, 32'h13FF, 32'hFFFFFFFC);
      vecs[27] = mk(E, 0, 32'h0,         1, 32'h04,        1, 32'h1000, 32'h00);
      vecs[28] = mk(L, 0, 32'h0,         1, 32'h00,        0, 32'h0,    32'h0);
      vecs[29] = mk(E, 0, 32'h0,         1, 32'h00,        0, 32'h0,    32'h0);
      vecs[30] = mk(E, 0, 32'h0,         1, 32'h04,        1, 32'h1000, 32'h00);

      rstn          = 1'b0;
      mode          = MODE_STALL;
      redirect      = 1'b0;
      redirect_pc   = '0;
      ifc.out_ready = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check_outs("reset", 32'h0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      rstn = 1'b1;

      for (int i = 0; i < 31; i++) begin
         @(negedge clk);
         mode          = vecs[i].mode;
         redirect      = vecs[i].redir;
         redirect_pc   = vecs[i].rpc;
         ifc.out_ready = vecs[i].ready;
         #1;
         check_outs($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].exp_valid,
                    vecs[i].exp_inst, vecs[i].exp_opc);
      end

      // Asynchronous reset asserted between clock edges while streaming.
      @(negedge clk);
      mode          = MODE_EXEC;
      redirect      = 1'b0;
      ifc.out_ready = 1'b1;
      @(posedge clk);
      #2;
      check_outs("pre_async", 32'h0C, 1'b1, 32'h1002, 32'h08);
      #1;
      rstn = 1'b0;
      #1;
      check_outs("async_rst", 32'h0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      rstn = 1'b1;
      #1;
      check_outs("post_rst0", 32'h0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      #1;
      check_outs("post_rst1", 32'h04, 1'b1, 32'h1000, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_fetch_ctrl
`default_nettype wire

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Front-end controller directly upstream of the instruction fetch stage. It owns the program counter and drives the fetch stage's pc, which is the synchronous INST_BRAM address, one request per cycle. It tracks the 1-cycle BRAM read latency, pairs each returned instruction with its pc, and presents them to decode through a valid/ready handshake. A 1-entry skid buffer absorbs decode stalls, and branch/jump redirects squash wrong-path fetches.

Parameters:
RESET_PC, 32'h0000_0000, pc value after reset and while mode==LOAD
INST_SIZE, package constant INST_SIZE, instruction BRAM address width (word index = pc[INST_SIZE+1:2])

Ports:
clk  in  1  system clock
rstn  in  1  reset; one clock; reset is asynchronous and active-low
mode  in  3  core mode: STALL=0, LOAD=1, EXEC=2; other values behave as STALL
redirect  in  1  taken branch/jump from execute; 1-cycle pulse
redirect_pc  in  32  redirect target; bits [1:0] ignored and forced to 0
pc  out  32  fetch address to fetch stage
inst_in  in  32  instruction from fetch stage; valid the cycle after pc was issued
out_valid  out  1  instruction available to decode
out_ready  in  1  decode accepts this cycle
out_inst  out  32  instruction to decode
out_pc  out  32  pc of out_inst

Behaviour:
- State: pc_q, inflight_v/inflight_pc (request issued last cycle), skid_v/skid_inst/skid_pc.
- Reset (async, rstn=0): pc_q=RESET_PC, inflight_v=0, skid_v=0. Outputs: pc=RESET_PC, out_valid=0, out_inst=0, out_pc=0.
- issue = (mode==EXEC) && !redirect && !skid_v && !(inflight_v && !out_ready).
- On issue: inflight_v<=1, inflight_pc<=pc_q, pc_q<=pc_q+4 (mod 2^32, wraps FFFF_FFFC->0). Otherwise inflight_v<=0 and pc_q holds.
- Output mux (combinational):
  - skid_v: out = skid entry.
  - else inflight_v && !redirect: out = {inst_in, inflight_pc}.
  - else out_valid=0, out_inst=0, out_pc=0.
- Skid load: inflight_v && !skid_v && !out_ready && !redirect -> skid <= {inst_in, inflight_pc}. Skid clears on out_valid&&out_ready while skid_v.
- Invariant: skid_v and inflight_v are never both 1 (guaranteed by issue). The bench asserts it.
- Throughput: 1 instr/cycle with out_ready=1. Pc-to-out_valid latency is 1 cycle.
- Handshake: once out_valid=1, out_inst/out_pc hold stable until transfer, except on redirect or LOAD. out_ready may depend on out_valid.
- Redirect at cycle t: out_valid forced 0 in t. Skid and inflight are squashed. pc_q<=redirect_pc&~3. First target instruction reaches out_valid at t+2.
- Redirect wins over a simultaneous out_ready transfer (nothing transfers in t) and over issue.
- mode==LOAD: pc_q<=RESET_PC, inflight_v<=0, skid_v<=0, out_valid=0.
- mode==STALL: no issue. Pending inflight/skid entries still drain to decode. pc_q holds.
- Leaving LOAD into EXEC: first issue is RESET_PC in the first EXEC cycle.

Decomposition:
- Shared package (constant): INST_SIZE; mode encodings MODE_STALL/MODE_LOAD/MODE_EXEC, moved out of the fetch stage's locals so fetch and fetch_ctrl share them; RESET_PC default; a fetch_entry_t struct {inst[31:0], pc[31:0]}.
- Sub-module fetch_skid: 1-entry skid register with load/clear/flush, holding a fetch_entry_t.
- Top level holds pc_q, inflight tracking, issue logic and the output mux.

Test Plan:
- Reset then mode=EXEC, out_ready=1, BRAM word i = 0x1000+i -> pc steps 0,4,8,… from the first EXEC cycle. out_valid rises 1 cycle later. Pairs (0x1000,0),(0x1001,4),… arrive 1/cycle with no gaps.
- Steady stream, drop out_ready for 3 cycles at out_pc=8 -> out holds (0x1002,8) stable. Skid used, issue stops, no duplicates or losses. On re-assert, the sequence continues at pc=0xC.
- Redirect pulse with redirect_pc=0x43 while out_pc=0x10 and out_ready=1 -> out_valid=0 that cycle, 0x10 not transferred. Next pc=0x40, and (word 0x10, 0x40) is output 2 cycles after the pulse.
- Redirect in the same cycle as skid_v=1 -> skid flushed. The next output is the redirect target; the stale skid entry never appears.
- mode EXEC->STALL with one request in flight -> that instruction is still delivered, pc holds, no further requests. Back to EXEC resumes at the held pc.
- Redirect to 0xFFFF_FFFC then continuous EXEC -> pc wraps to 0x0000_0000. Async rstn low mid-stream (not clock-aligned) -> out_valid=0 and pc=RESET_PC immediately.
